// File: rtl/sample_mac_pipe.sv
// sample_mac_pipe: pipelined multiply-accumulate with shift,
// saturation/truncation and a valid/ready stream handshake.
module sample_mac_pipe #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 14,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 1,
    parameter int NUM_STAGE = 2,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 14,
    parameter int SHIFT     = 0,
    parameter int SAT_EN    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 ovf
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH + 2;
    localparam int LAST    = NUM_STAGE - 1;

    logic advance;

    assign advance  = ce & ~(dout_valid & ~dout_ready);
    assign in_ready = advance;

    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               v_q;
    logic               f_q;
    logic               l_q;

    // Operand register: captures the offered beat (or a bubble) on advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
        end else if (advance) begin
            a_q <= din0;
            b_q <= din1;
            v_q <= in_valid;
            f_q <= in_first;
            l_q <= in_last;
        end
    end

    logic signed [A_WIDTH:0]   a_ext;
    logic signed [B_WIDTH:0]   b_ext;
    logic signed [P_WIDTH-1:0] a_w;
    logic signed [P_WIDTH-1:0] b_w;
    logic signed [P_WIDTH-1:0] prod;

    assign a_ext = {(A_SIGNED != 0) && a_q[A_WIDTH-1], a_q};
    assign b_ext = {(B_SIGNED != 0) && b_q[B_WIDTH-1], b_q};
    assign a_w   = P_WIDTH'(a_ext);
    assign b_w   = P_WIDTH'(b_ext);
    assign prod  = a_w * b_w;

    logic signed [ACC_WIDTH-1:0] p_prod [NUM_STAGE];
    logic [NUM_STAGE-1:0]        p_v;
    logic [NUM_STAGE-1:0]        p_f;
    logic [NUM_STAGE-1:0]        p_l;

    // Product pipeline: full-width product travels with its tags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_v <= '0;
            p_f <= '0;
            p_l <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                p_prod[i] <= '0;
            end
        end else if (advance) begin
            p_v[0]    <= v_q;
            p_f[0]    <= f_q;
            p_l[0]    <= l_q;
            p_prod[0] <= ACC_WIDTH'(prod);
            for (int i = 1; i < NUM_STAGE; i++) begin
                p_v[i]    <= p_v[i-1];
                p_f[i]    <= p_f[i-1];
                p_l[i]    <= p_l[i-1];
                p_prod[i] <= p_prod[i-1];
            end
        end
    end

    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   r;
    logic [ACC_WIDTH-OUT_WIDTH:0]  r_hi;
    logic                          fits;
    logic [OUT_WIDTH-1:0]          clamp;
    logic [OUT_WIDTH-1:0]          res;
    logic                          res_ovf;

    // Accumulate, shift, and fit the result into the signed output range.
    always_comb begin
        acc_next = p_f[LAST] ? p_prod[LAST] : acc + p_prod[LAST];
        r        = acc_next >>> SHIFT;
        r_hi     = r[ACC_WIDTH-1:OUT_WIDTH-1];
        fits     = (&r_hi) | ~(|r_hi);
        clamp    = r[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        res      = r[OUT_WIDTH-1:0];
        res_ovf  = ~fits;
        if ((SAT_EN != 0) && !fits) begin
            res = clamp;
        end
    end

    // Accumulator: loads on first, adds otherwise, clears after a last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (advance && p_v[LAST]) begin
            acc <= p_l[LAST] ? '0 : acc_next;
        end
    end

    // Output register: loads on a last beat, drops valid on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            ovf        <= 1'b0;
            dout_valid <= 1'b0;
        end else if (advance && p_v[LAST] && p_l[LAST]) begin
            dout       <= res;
            ovf        <= res_ovf;
            dout_valid <= 1'b1;
        end else if (advance) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
